// File: rtl/stream_fifo_rr_arbiter.sv
// Round-robin arbiter feeding one shared flushable FIFO; every stored beat carries its source index.
// Optional packet locking (grant held until a last beat) is built when STREAM_FIFO_ARB_LOCK_EN is defined.
module stream_fifo_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int SRC_W     = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
`ifdef STREAM_FIFO_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_last_i,
`endif
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          r_valid_o,
  input  logic                          r_ready_i,
  output logic [DATA_WIDTH-1:0]         r_data_o,
  output logic [SRC_W-1:0]              r_src_o,
  output logic [CNT_W-1:0]              count_o,
  input  logic                          flush_req_i,
  output logic                          flush_done_o
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENTRY_W = DATA_WIDTH + SRC_W;

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

  state_t                 state;
  logic [SRC_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [ENTRY_W-1:0]     mem [FIFO_DEPTH];

  logic                   gated;
  logic                   full;
  logic                   empty;
  logic                   grant_any;
  logic [SRC_W-1:0]       grant_idx;
  logic [DATA_WIDTH-1:0]  grant_data;
  logic                   push;
  logic                   pop;

`ifdef STREAM_FIFO_ARB_LOCK_EN
  logic                   lock_active;
  logic [SRC_W-1:0]       lock_idx;
`endif

  function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum -= NUM_REQ;
    return SRC_W'(sum);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Flush request blocks traffic already in its request cycle; reset blocks it combinationally too.
  assign gated = !rst_n || (state != IDLE) || flush_req_i;
  assign full  = (count_o == CNT_W'(FIFO_DEPTH));
  assign empty = (count_o == '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_any = 1'b0;
    grant_idx = '0;
    // Scan downward so the index closest to rr_ptr is the last (winning) assignment.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[wrap_add(rr_ptr, k)]) begin
        grant_any = 1'b1;
        grant_idx = wrap_add(rr_ptr, k);
      end
    end
`ifdef STREAM_FIFO_ARB_LOCK_EN
    if (lock_active) begin
      grant_any = req_valid_i[lock_idx];
      grant_idx = lock_idx;
    end
`endif
  end

  assign grant_data  = req_data_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign push        = grant_any && !full && !gated;
  assign req_ready_o = push ? (NUM_REQ'(1) << grant_idx) : '0;
  assign r_valid_o   = !empty && !gated;
  assign pop         = r_valid_o && r_ready_i;
  assign r_data_o    = mem[rd_ptr][DATA_WIDTH-1:0];
  assign r_src_o     = mem[rd_ptr][ENTRY_W-1:DATA_WIDTH];

  // NOTE: storage carries no reset; occupancy lives in count_o, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {grant_idx, grant_data};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      flush_done_o <= 1'b0;
      rr_ptr       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_o      <= '0;
`ifdef STREAM_FIFO_ARB_LOCK_EN
      lock_active  <= 1'b0;
      lock_idx     <= '0;
`endif
    end else begin
      flush_done_o <= (state == FLUSH);
      case (state)
        IDLE:    if (flush_req_i) state <= FLUSH;
        FLUSH:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (state == FLUSH) begin
        rr_ptr  <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_o <= '0;
`ifdef STREAM_FIFO_ARB_LOCK_EN
        lock_active <= 1'b0;
`endif
      end else begin
        if (push) begin
          wr_ptr <= ptr_inc(wr_ptr);
`ifdef STREAM_FIFO_ARB_LOCK_EN
          if (req_last_i[grant_idx]) begin
            lock_active <= 1'b0;
            rr_ptr      <= wrap_add(grant_idx, 1);
          end else begin
            lock_active <= 1'b1;
            lock_idx    <= grant_idx;
          end
`else
          rr_ptr <= wrap_add(grant_idx, 1);
`endif
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        case ({push, pop})
          2'b10:   count_o <= count_o + CNT_W'(1);
          2'b01:   count_o <= count_o - CNT_W'(1);
          default: count_o <= count_o;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_fifo_rr_arbiter.sv
// Self-checking bench for stream_fifo_rr_arbiter: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_stream_fifo_rr_arbiter;
  localparam int NR    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int SW    = 2;
  localparam int CW    = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_ready;
  logic              r_valid;
  logic              r_ready = 1'b0;
  logic [DW-1:0]     r_data;
  logic [SW-1:0]     r_src;
  logic [CW-1:0]     count;
  logic              flush_req = 1'b0;
  logic              flush_done;
`ifdef STREAM_FIFO_ARB_LOCK_EN
  logic [NR-1:0]     req_last = '1;
`endif

  stream_fifo_rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
`ifdef STREAM_FIFO_ARB_LOCK_EN
    .req_last_i   (req_last),
`endif
    .req_ready_o  (req_ready),
    .r_valid_o    (r_valid),
    .r_ready_i    (r_ready),
    .r_data_o     (r_data),
    .r_src_o      (r_src),
    .count_o      (count),
    .flush_req_i  (flush_req),
    .flush_done_o (flush_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data_a();
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'hA0 + 32'(i);
  endtask

  task automatic check_basic(input string tag, input logic [NR-1:0] e_ready, input logic e_rvalid,
                             input int e_count, input logic e_done);
    check({tag, "_ready"}, req_ready, e_ready);
    check({tag, "_rvalid"}, r_valid, e_rvalid);
    check({tag, "_count"}, count, 64'(e_count));
    check({tag, "_done"}, flush_done, e_done);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] data;
    int            src;
  } beat_t;

  beat_t q[$];
  int    m_rr;
  int    m_phase;   // 0 idle, 1 flushing, 2 flush done

  task automatic model_reset();
    q.delete();
    m_rr    = 0;
    m_phase = 0;
  endtask

  task automatic model_cycle();
    int            g;
    logic          blocked;
    logic [NR-1:0] e_ready;
    logic          e_rvalid;
    blocked = (m_phase != 0) || flush_req;
    g = -1;
    for (int k = 0; k < NR; k++) begin
      if (g < 0 && req_valid[(m_rr + k) % NR]) g = (m_rr + k) % NR;
    end
    e_ready  = (!blocked && g >= 0 && q.size() < DEPTH) ? (NR'(1) << g) : '0;
    e_rvalid = !blocked && q.size() > 0;
    check("rnd_ready", req_ready, e_ready);
    check("rnd_rvalid", r_valid, e_rvalid);
    check("rnd_count", count, 64'(q.size()));
    check("rnd_done", flush_done, m_phase == 2);
    if (e_rvalid) begin
      check("rnd_data", r_data, q[0].data);
      check("rnd_src", r_src, 64'(q[0].src));
    end
    if (e_rvalid && r_ready) void'(q.pop_front());
    if (e_ready != '0) begin
      q.push_back('{req_data[g*DW +: DW], g});
      m_rr = (g + 1) % NR;
    end
    case (m_phase)
      0: if (flush_req) m_phase = 1;
      1: begin
        q.delete();
        m_rr    = 0;
        m_phase = 2;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    r_ready   = 1'b0;
    flush_req = 1'b0;
`ifdef STREAM_FIFO_ARB_LOCK_EN
    req_last  = '1;
`endif
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [NR-1:0] valid;
    logic          rready;
    logic          flush;
    logic [NR-1:0] e_ready;
    logic          e_rvalid;
    int            e_count;
    logic [7:0]    e_data;
    int            e_src;
    logic          e_done;
  } vec_t;

  vec_t vecs[14];
  int   hold;

  initial begin
    // Fill with all four valid and consumer stalled, then drain in order.
    vecs[0]  = '{4'hF, 1'b0, 1'b0, 4'b0001, 1'b0, 0, 8'h00, 0, 1'b0};
    vecs[1]  = '{4'hF, 1'b0, 1'b0, 4'b0010, 1'b1, 1, 8'hA0, 0, 1'b0};
    vecs[2]  = '{4'hF, 1'b0, 1'b0, 4'b0100, 1'b1, 2, 8'hA0, 0, 1'b0};
    vecs[3]  = '{4'hF, 1'b0, 1'b0, 4'b1000, 1'b1, 3, 8'hA0, 0, 1'b0};
    vecs[4]  = '{4'hF, 1'b0, 1'b0, 4'b0000, 1'b1, 4, 8'hA0, 0, 1'b0};
    vecs[5]  = '{4'h0, 1'b1, 1'b0, 4'b0000, 1'b1, 4, 8'hA0, 0, 1'b0};
    vecs[6]  = '{4'h0, 1'b1, 1'b0, 4'b0000, 1'b1, 3, 8'hA1, 1, 1'b0};
    vecs[7]  = '{4'h0, 1'b1, 1'b0, 4'b0000, 1'b1, 2, 8'hA2, 2, 1'b0};
    vecs[8]  = '{4'h0, 1'b1, 1'b0, 4'b0000, 1'b1, 1, 8'hA3, 3, 1'b0};
    vecs[9]  = '{4'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 0, 8'h00, 0, 1'b0};
    // Only requesters 1 and 3 valid: grants alternate 1,3,1,3.
    vecs[10] = '{4'hA, 1'b1, 1'b0, 4'b0010, 1'b0, 0, 8'h00, 0, 1'b0};
    vecs[11] = '{4'hA, 1'b1, 1'b0, 4'b1000, 1'b1, 1, 8'hA1, 1, 1'b0};
    vecs[12] = '{4'hA, 1'b1, 1'b0, 4'b0010, 1'b1, 1, 8'hA3, 3, 1'b0};
    vecs[13] = '{4'hA, 1'b1, 1'b0, 4'b1000, 1'b1, 1, 8'hA1, 1, 1'b0};

    set_data_a();
    rst_n     = 1'b0;
    req_valid = 4'hF;
    #2;
    check_basic("reset", 4'b0000, 1'b0, 0, 1'b0);
    do_reset();
    set_data_a();

    for (int r = 0; r < 14; r++) begin
      req_valid = vecs[r].valid;
      r_ready   = vecs[r].rready;
      flush_req = vecs[r].flush;
      #1;
      check_basic($sformatf("vec%0d", r), vecs[r].e_ready, vecs[r].e_rvalid,
                  vecs[r].e_count, vecs[r].e_done);
      if (vecs[r].e_rvalid) begin
        check($sformatf("vec%0d_data", r), r_data, 64'(vecs[r].e_data));
        check($sformatf("vec%0d_src", r), r_src, 64'(vecs[r].e_src));
      end
      tick();
    end

    // Flush at count 2 with a one-cycle request pulse.
    do_reset();
    req_valid = 4'b0011;
    #1 check("fl_push0", req_ready, 4'b0001);
    tick();
    #1 check("fl_push1", req_ready, 4'b0010);
    tick();
    req_valid = 4'hF;
    r_ready   = 1'b1;
    flush_req = 1'b1;
    #1 check_basic("fl_reqcyc", 4'b0000, 1'b0, 2, 1'b0);
    tick();
    flush_req = 1'b0;
    #1 check_basic("fl_flush", 4'b0000, 1'b0, 2, 1'b0);
    tick();
    #1 check_basic("fl_done", 4'b0000, 1'b0, 0, 1'b1);
    tick();
    #1 check_basic("fl_after", 4'b0001, 1'b0, 0, 1'b0);
    req_valid = '0;
    tick();

    // Full FIFO: a pop does not enable a same-cycle push.
    do_reset();
    req_valid = 4'hF;
    repeat (4) tick();
    req_valid = 4'b0100;
    r_ready   = 1'b1;
    #1 check_basic("full_pop", 4'b0000, 1'b1, 4, 1'b0);
    tick();
    r_ready = 1'b0;
    #1 check_basic("full_push", 4'b0100, 1'b1, 3, 1'b0);
    tick();
    #1 check_basic("full_again", 4'b0000, 1'b1, 4, 1'b0);
    req_valid = '0;
    tick();

    // Reset asserted while in FLUSH: no completion pulse afterwards.
    do_reset();
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    #1 rst_n = 1'b0;
    req_valid = 4'hF;
    #1 check_basic("rstfl_in", 4'b0000, 1'b0, 0, 1'b0);
    tick();
    rst_n = 1'b1;
    #1 check_basic("rstfl_c1", 4'b0001, 1'b0, 0, 1'b0);
    tick();
    #1 check_basic("rstfl_c2", 4'b0010, 1'b1, 1, 1'b0);
    req_valid = '0;
    tick();

`ifdef STREAM_FIFO_ARB_LOCK_EN
    // Requester 0 sends a three-beat packet while requester 1 waits.
    do_reset();
    req_valid = 4'b0011;
    for (int b = 0; b < 3; b++) begin
      req_data[0 +: DW] = 32'hB0 + 32'(b);
      req_last[0]       = (b == 2);
      #1 check($sformatf("lock_beat%0d", b), req_ready, 4'b0001);
      tick();
    end
    #1 check("lock_next", req_ready, 4'b0010);
    check("lock_count", count, 3);
    req_valid = '0;
    req_last  = '1;
    r_ready   = 1'b1;
    for (int b = 0; b < 3; b++) begin
      #1 check($sformatf("lock_src%0d", b), r_src, 0);
      check($sformatf("lock_data%0d", b), r_data, 32'hB0 + 32'(b));
      tick();
    end
`endif

    // Randomized traffic against the reference model; flush requests sometimes held several cycles.
    do_reset();
    hold = 0;
    for (int c = 0; c < 600; c++) begin
      req_valid = NR'($urandom);
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = $urandom;
      r_ready = ($urandom_range(0, 3) != 0);
      if (hold > 0) hold--;
      else if ($urandom_range(0, 24) == 0) hold = $urandom_range(1, 5);
      flush_req = (hold > 0);
      #1 model_cycle();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
